// File: rtl/sound_pkg.sv
// Shared sound event codes and decoder types, used by both the generator and the decoder.
package sound_pkg;

   localparam logic [3:0] CODE_FAILURE   = 4'd9;
   localparam logic [3:0] CODE_SUCCESS   = 4'd3;
   localparam logic [3:0] CODE_EAT_START = 4'd3;
   localparam logic [3:0] CODE_INPUT     = 4'd4;
   localparam logic [3:0] CODE_TICK      = 4'd5;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_TONE,
      DEC_GAP
   } dec_state_t;

   typedef enum logic [2:0] {
      EV_INPUT,
      EV_TICK,
      EV_EAT,
      EV_SUCCESS,
      EV_FAILURE,
      EV_UNKNOWN
   } dec_event_t;

endpackage

// File: rtl/sound_period_meter.sv
// Half-period meter: counts pwm_base ticks between audio edges and strobes a code.
module sound_period_meter #(
   parameter int HP_SAT = 31
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_base,
   input  logic       audio,
   output logic       code_valid,
   output logic [3:0] code
);

   logic       pwm_prev;
   logic       audio_prev;
   logic [4:0] hp;
   logic       pwm_edge;
   logic       audio_edge;

   assign pwm_edge   = pwm_base & ~pwm_prev;
   assign audio_edge = audio ^ audio_prev;

   // Edge history, tick counter and registered code strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_prev   <= 1'b0;
         audio_prev <= 1'b0;
         hp         <= 5'd0;
         code_valid <= 1'b0;
         code       <= 4'd0;
      end else begin
         pwm_prev   <= pwm_base;
         audio_prev <= audio;
         code_valid <= 1'b0;
         if (audio_edge) begin
            // A zero or saturated count means the previous edge was too long ago
            // (or never happened), so this edge only restarts the measurement.
            if (hp >= 5'd1 && hp <= 5'd16) begin
               code_valid <= 1'b1;
               code       <= 4'(hp - 5'd1);
            end
            hp <= pwm_edge ? 5'd1 : 5'd0;
         end else if (pwm_edge && hp != 5'(HP_SAT)) begin
            hp <= hp + 5'd1;
         end
      end
   end

endmodule

// File: rtl/sound_decoder.sv
// Sound event decoder: builds one record per vsync frame and classifies each sound
// by its start code and envelope (steady, swept or gated).
module sound_decoder
   import sound_pkg::*;
#(
   parameter int END_GAP   = 5,
   parameter int SWEEP_MIN = 6,
   parameter int HP_SAT    = 31
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       pwm_base,
   input  logic       audio,
   output logic       evt_new_input,
   output logic       evt_tick,
   output logic       evt_eat,
   output logic       evt_success,
   output logic       evt_failure,
   output logic       evt_unknown,
   output logic [3:0] tone_code,
   output logic       tone_valid
);

   logic       code_valid;
   logic [3:0] code;
   logic       vsync_prev;
   logic       vsync_edge;
   logic       frame_active;
   logic [3:0] frame_code;

   dec_state_t state;
   logic [4:0] frames;
   logic [4:0] gap;
   logic [3:0] start_code;
   logic [3:0] prev_code;
   logic       swept;
   logic       gated;
   logic       mismatch;
   logic [4:0] frames_inc;
   logic [4:0] gap_inc;
   dec_event_t sound_ev;

   function automatic dec_event_t classify(input logic sw, input logic gt,
                                           input logic mm, input logic [3:0] sc);
      dec_event_t ev;
      if (sw)                             ev = EV_EAT;
      else if (gt && sc == CODE_FAILURE)  ev = EV_FAILURE;
      else if (gt && sc == CODE_SUCCESS)  ev = EV_SUCCESS;
      else if (!gt && !mm && sc == CODE_INPUT) ev = EV_INPUT;
      else if (!gt && !mm && sc == CODE_TICK)  ev = EV_TICK;
      else                                ev = EV_UNKNOWN;
      return ev;
   endfunction

   sound_period_meter #(.HP_SAT(HP_SAT)) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_base   (pwm_base),
      .audio      (audio),
      .code_valid (code_valid),
      .code       (code)
   );

   assign vsync_edge = vsync & ~vsync_prev;
   assign frames_inc = (frames == 5'd31) ? frames : frames + 5'd1;
   assign gap_inc    = gap + 5'd1;
   assign sound_ev   = classify(swept, gated, mismatch, start_code);

   // Frame record; a code arriving on the closing cycle already belongs to the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_prev   <= 1'b0;
         frame_active <= 1'b0;
         frame_code   <= 4'd0;
         tone_code    <= 4'd0;
      end else begin
         vsync_prev <= vsync;
         if (code_valid) tone_code <= code;
         if (vsync_edge) begin
            frame_active <= code_valid;
            frame_code   <= code_valid ? code : 4'd0;
         end else if (code_valid) begin
            frame_active <= 1'b1;
            frame_code   <= code;
         end
      end
   end

   // Envelope FSM stepped once per frame, with registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= DEC_IDLE;
         frames        <= 5'd0;
         gap           <= 5'd0;
         start_code    <= 4'd0;
         prev_code     <= 4'd0;
         swept         <= 1'b0;
         gated         <= 1'b0;
         mismatch      <= 1'b0;
         tone_valid    <= 1'b0;
         evt_new_input <= 1'b0;
         evt_tick      <= 1'b0;
         evt_eat       <= 1'b0;
         evt_success   <= 1'b0;
         evt_failure   <= 1'b0;
         evt_unknown   <= 1'b0;
      end else begin
         evt_new_input <= 1'b0;
         evt_tick      <= 1'b0;
         evt_eat       <= 1'b0;
         evt_success   <= 1'b0;
         evt_failure   <= 1'b0;
         evt_unknown   <= 1'b0;
         if (vsync_edge) begin
            case (state)
               DEC_IDLE: begin
                  if (frame_active) begin
                     state      <= DEC_TONE;
                     frames     <= 5'd1;
                     start_code <= frame_code;
                     prev_code  <= frame_code;
                     swept      <= 1'b0;
                     gated      <= 1'b0;
                     mismatch   <= 1'b0;
                     tone_valid <= 1'b1;
                  end
               end
               DEC_TONE: begin
                  if (frame_active) begin
                     frames    <= frames_inc;
                     prev_code <= frame_code;
                     // An early pitch change is a merged/odd sound, a late one a sweep.
                     if (frame_code != prev_code) begin
                        if (frames_inc >= 5'(SWEEP_MIN)) swept    <= 1'b1;
                        else                             mismatch <= 1'b1;
                     end
                  end else begin
                     state <= DEC_GAP;
                     gap   <= 5'd1;
                  end
               end
               DEC_GAP: begin
                  if (frame_active) begin
                     state <= DEC_TONE;
                     gated <= 1'b1;
                  end else if (gap_inc == 5'(END_GAP)) begin
                     state         <= DEC_IDLE;
                     tone_valid    <= 1'b0;
                     evt_new_input <= (sound_ev == EV_INPUT);
                     evt_tick      <= (sound_ev == EV_TICK);
                     evt_eat       <= (sound_ev == EV_EAT);
                     evt_success   <= (sound_ev == EV_SUCCESS);
                     evt_failure   <= (sound_ev == EV_FAILURE);
                     evt_unknown   <= (sound_ev == EV_UNKNOWN);
                  end else begin
                     gap <= gap_inc;
                  end
               end
               default: state <= DEC_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sound_decoder.sv
// Directed bench for sound_decoder: plays frame-by-frame square waves and checks decoded events.
module tb_sound_decoder;
   import sound_pkg::*;

   localparam int TICKS = 48;   // pwm ticks per frame

   // Event identifiers used in the observed-event log
   localparam int E_INPUT = 1, E_TICK = 2, E_EAT = 3, E_SUCCESS = 4, E_FAILURE = 5, E_UNKNOWN = 6;

   logic       clk;
   logic       rst_n;
   logic       vsync;
   logic       pwm_base;
   logic       audio;
   logic       evt_new_input, evt_tick, evt_eat, evt_success, evt_failure, evt_unknown;
   logic [3:0] tone_code;
   logic       tone_valid;

   int n_vec;
   int n_err;
   int ev_log[$];

   sound_decoder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .vsync         (vsync),
      .pwm_base      (pwm_base),
      .audio         (audio),
      .evt_new_input (evt_new_input),
      .evt_tick      (evt_tick),
      .evt_eat       (evt_eat),
      .evt_success   (evt_success),
      .evt_failure   (evt_failure),
      .evt_unknown   (evt_unknown),
      .tone_code     (tone_code),
      .tone_valid    (tone_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every cycle each event output is high; a wide pulse shows up as repeats.
   always @(posedge clk) begin
      if (evt_new_input) ev_log.push_back(E_INPUT);
      if (evt_tick)      ev_log.push_back(E_TICK);
      if (evt_eat)       ev_log.push_back(E_EAT);
      if (evt_success)   ev_log.push_back(E_SUCCESS);
      if (evt_failure)   ev_log.push_back(E_FAILURE);
      if (evt_unknown)   ev_log.push_back(E_UNKNOWN);
   end

   // One frame: vsync pulse, then TICKS pwm ticks; audio toggles every hp ticks when on.
   task automatic play_frame(input int hp, input bit on);
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) vsync = 1'b0;
      for (int t = 0; t < TICKS; t++) begin
         pwm_base = 1'b1;
         if (on && (t % hp) == 0) audio = ~audio;
         @(negedge clk) pwm_base = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic play_tone(input int code, input int nframes);
      for (int f = 0; f < nframes; f++) play_frame(code + 1, 1'b1);
   endtask

   task automatic silence(input int nframes);
      for (int f = 0; f < nframes; f++) play_frame(1, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; vsync = 1'b0; pwm_base = 1'b0; audio = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if ({evt_new_input, evt_tick, evt_eat, evt_success, evt_failure, evt_unknown} !== 6'b0) begin
         n_err++; $display("FAIL reset_events: got %b want 000000",
            {evt_new_input, evt_tick, evt_eat, evt_success, evt_failure, evt_unknown});
      end
      n_vec++;
      if (tone_code !== 4'd0) begin n_err++; $display("FAIL reset_tone_code: got %0d want 0", tone_code); end
      n_vec++;
      if (tone_valid !== 1'b0) begin n_err++; $display("FAIL reset_tone_valid: got %b want 0", tone_valid); end
      rst_n = 1'b1;
      silence(1);
   endtask

   task automatic test_new_input;
      ev_log.delete();
      play_tone(CODE_INPUT, 4);
      n_vec++;
      if (tone_valid !== 1'b1) begin n_err++; $display("FAIL input_tone_valid: got %b want 1", tone_valid); end
      silence(6);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_INPUT) begin
         n_err++; $display("FAIL input_event: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_INPUT);
      end
      n_vec++;
      if (tone_code !== 4'd4) begin n_err++; $display("FAIL input_tone_code: got %0d want 4", tone_code); end
      n_vec++;
      if (tone_valid !== 1'b0) begin n_err++; $display("FAIL input_end_valid: got %b want 0", tone_valid); end
   endtask

   task automatic test_tick;
      ev_log.delete();
      play_tone(CODE_TICK, 1);
      silence(2);
      n_vec++;
      if (tone_valid !== 1'b1) begin n_err++; $display("FAIL tick_gap_valid: got %b want 1", tone_valid); end
      silence(4);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_TICK) begin
         n_err++; $display("FAIL tick_event: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_TICK);
      end
      n_vec++;
      if (tone_code !== 4'd5) begin n_err++; $display("FAIL tick_tone_code: got %0d want 5", tone_code); end
      n_vec++;
      if (tone_valid !== 1'b0) begin n_err++; $display("FAIL tick_end_valid: got %b want 0", tone_valid); end
   endtask

   task automatic test_failure_gated;
      ev_log.delete();
      for (int b = 0; b < 3; b++) begin
         play_tone(CODE_FAILURE, 4);
         silence(4);
      end
      n_vec++;
      if (ev_log.size() != 0) begin
         n_err++; $display("FAIL gated_no_early_pulse: got %0d events want 0", ev_log.size());
      end
      n_vec++;
      if (tone_valid !== 1'b1) begin n_err++; $display("FAIL gated_valid: got %b want 1", tone_valid); end
      silence(2);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_FAILURE) begin
         n_err++; $display("FAIL gated_failure_event: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_FAILURE);
      end
      n_vec++;
      if (tone_code !== 4'd9) begin n_err++; $display("FAIL gated_tone_code: got %0d want 9", tone_code); end
   endtask

   task automatic test_eat_sweep;
      int c;
      ev_log.delete();
      c = int'(CODE_EAT_START);
      for (int f = 0; f < 24; f++) begin
         play_tone(c, 1);
         c = (f < 12) ? c + 1 : c - 1;
      end
      silence(6);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_EAT) begin
         n_err++; $display("FAIL sweep_eat_event: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_EAT);
      end
      n_vec++;
      if (tone_code !== 4'd4) begin n_err++; $display("FAIL sweep_tone_code: got %0d want 4", tone_code); end
   endtask

   task automatic test_short_sweep;
      ev_log.delete();
      for (int f = 0; f < 3; f++) play_tone(int'(CODE_EAT_START) + f, 1);
      silence(6);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_UNKNOWN) begin
         n_err++; $display("FAIL short_sweep_unknown: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_UNKNOWN);
      end
   endtask

   task automatic test_back_to_back;
      int exp_ev[5];
      exp_ev = '{E_TICK, E_INPUT, E_EAT, E_SUCCESS, E_FAILURE};
      ev_log.delete();
      play_tone(CODE_TICK, 1);  silence(6);
      play_tone(CODE_INPUT, 4); silence(6);
      for (int f = 0; f < 8; f++) play_tone(int'(CODE_EAT_START) + f, 1);
      silence(6);
      play_tone(CODE_SUCCESS, 2); silence(2); play_tone(CODE_SUCCESS, 2); silence(6);
      play_tone(CODE_FAILURE, 2); silence(2); play_tone(CODE_FAILURE, 2); silence(6);
      n_vec++;
      if (ev_log.size() != 5) begin
         n_err++; $display("FAIL b2b_count: got %0d events want 5", ev_log.size());
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (i >= ev_log.size() || ev_log[i] != exp_ev[i]) begin
            n_err++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i,
               (i < ev_log.size()) ? ev_log[i] : -1, exp_ev[i]);
         end
      end
   endtask

   task automatic test_reset_mid_tone;
      ev_log.delete();
      play_tone(CODE_FAILURE, 4);
      silence(2);
      play_tone(CODE_FAILURE, 2);
      n_vec++;
      if (tone_valid !== 1'b1) begin n_err++; $display("FAIL midreset_pre_valid: got %b want 1", tone_valid); end
      @(negedge clk);
      rst_n = 1'b0;
      audio = 1'b0;
      #1;
      n_vec++;
      if (tone_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", tone_valid); end
      n_vec++;
      if (tone_code !== 4'd0) begin n_err++; $display("FAIL midreset_tone_code: got %0d want 0", tone_code); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      silence(7);
      n_vec++;
      if (ev_log.size() != 0) begin
         n_err++; $display("FAIL midreset_no_pulse: got %0d events want 0", ev_log.size());
      end
      play_tone(CODE_TICK, 1);
      silence(6);
      n_vec++;
      if (ev_log.size() != 1 || ev_log[0] != E_TICK) begin
         n_err++; $display("FAIL midreset_next_sound: got %0d events (first %0d) want 1 event %0d",
            ev_log.size(), (ev_log.size() > 0) ? ev_log[0] : 0, E_TICK);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_new_input();
      test_tick();
      test_failure_gated();
      test_eat_sweep();
      test_short_sweep();
      test_back_to_back();
      test_reset_mid_tone();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
